ysyx_041461_mul_final: RTL and testbench
========================================

# ysyx_041461_mul_final

Final stage of the 64-bit Booth/Wallace multiplier, directly downstream of the 132-column Wallace tree built from 33-bit column slices. Takes each column's final carry and sum bit and adds them with a carry-propagate adder. Selects the RV64M result for the operation and holds it in an output register behind a valid/ready handshake. Also owns the sideband tag pipeline (valid, op) that tracks operations through the tree's internal register stages, and gates issue so only one multiply is in flight.

## Interface
- `TREE_LAT`, 3: number of register stages inside the Wallace tree (cycles from operand issue to valid column outputs).
- `COLS`, 132: number of tree columns.
- `XLEN`, 64: result width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset; **synchronous, active-high**.
- `in_valid`  in  1  operands enter the tree this cycle.
- `in_op`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5–7 reserved.
- `in_ready`  out  1  block can accept an issue this cycle.
- `in_flush`  in  1  kill any in-flight or buffered operation.
- `tree_c`  in  COLS  per-column final carry (`Walloc_33bits_cout` of column i).
- `tree_s`  in  COLS  per-column final sum (`Walloc_33bits_sout` of column i).
- `out_valid`  out  1  `out_result` holds a valid result.
- `out_ready`  in  1  consumer accepts the result.
- `out_result`  out  XLEN  selected result.
- `busy`  out  1  any tag in flight or `out_valid` high.

## Operation
- **Accept:** an issue is accepted when `in_valid && in_ready && !in_flush`. `in_ready = !busy`. If `in_valid` is asserted while `in_ready` is low, the issue is dropped and no tag is created.
- **Tag pipeline:** a TREE_LAT-deep shift register of {valid, op}.
  - Stage 0 loads {accepted, `in_op`}.
  - Each later stage loads the previous stage every cycle; the tree never stalls.
- **Final add:** at the tail, `sum[127:0] = tree_s[127:0] + (tree_c[126:0] << 1)`, modulo 2^128. Columns 128–131 and `tree_c[127]` are discarded.
- **Result select:**
  - MUL: `sum[63:0]`.
  - MULH, MULHSU, MULHU: `sum[127:64]`. Signedness is already encoded upstream in the Booth partial products.
  - MULW: sign-extend `sum[31:0]` to 64 bits.
  - Reserved op codes: 0.
- **Output register:** loads the selected result and sets `out_valid` when the tail tag is valid. `out_valid` clears on `out_ready`.
  - A single outstanding op means the tail never arrives while `out_valid` is high.
  - The implementation asserts this condition in simulation.
- **Flush:**
  - Next cycle: every tag valid bit and `out_valid` are 0.
  - `out_result` keeps its stale value.
  - Flush wins over a same-cycle issue, tail arrival, or handshake.
- **Reset:** all tag bits, `out_valid`, and `out_result` go to 0. Reset mid-operation discards the op. `in_ready` is 1 in the first cycle after reset.

## Timing
- An issue accepted in cycle t puts the tail tag valid in cycle t+TREE_LAT, with `tree_c`/`tree_s` valid in that same cycle. `out_valid` rises in cycle t+TREE_LAT+1, i.e. latency 4 at default parameters.
- `out_result` is stable while `out_valid && !out_ready`.
- `busy` and `in_ready` are combinational from registered state only. There is no path from `in_valid` or `out_ready` to them.
- Back-to-back throughput:
  - Next issue is possible in the cycle after the `out_ready` handshake.
  - Minimum spacing is TREE_LAT+2 cycles with `out_ready` held high.
- The 128-bit carry-propagate add sits in one cycle between the tree's last register and `out_result`.

## Structure
- Shared package `ysyx_041461_mul_pkg` holds:
  - op-code localparams (MUL..MULW);
  - TREE_LAT, COLS, XLEN;
  - the tag struct/width.
- One sub-module, `ysyx_041461_mul_tagpipe`, implements the parameterised valid/op shift register with synchronous clear. The top holds the adder, the select logic, the output register, and the handshake.

## Test plan
- **Basic MUL:** issue MUL at t=10; at t=13 drive `tree_s=15`, `tree_c=0`. Required: `out_valid` at t=14 with `out_result=15`; `in_ready=0` for t=11..14.
- **Carry path:** MUL with `tree_s=2^64-1`, `tree_c=1` gives `out_result=1`. Repeat with MULHU on the same vectors: `out_result=1`.
- **MULW sign extension:** `tree_s=0x8000_0000`, `tree_c=0` gives `0xFFFF_FFFF_8000_0000`. MULH with `sum=2^128-1` gives `0xFFFF_FFFF_FFFF_FFFF`.
- **Backpressure:** hold `out_ready=0` for 5 cycles after `out_valid`. Required: `out_result` constant, `in_ready=0`, and an `in_valid` pulse is dropped (no second `out_valid`). After the handshake, `in_ready=1` next cycle.
- **Flush:** issue at t=10, flush at t=12. Required: no `out_valid` ever, `in_ready=1` at t=13. Flush in the same cycle as an issue: no tag created.
- **Reset mid-op:** issue at t=10, `rst` at t=11..12. Required: `out_valid=0` throughout, `in_ready=1` at t=13, and the next op completes normally.

Source files
------------

// File: rtl/ysyx_041461_mul_pkg.sv
// rtl/ysyx_041461_mul_pkg.sv - shared op codes, sizes and tag type for the multiplier final stage
package ysyx_041461_mul_pkg;

    localparam int TREE_LAT = 3;
    localparam int COLS     = 132;
    localparam int XLEN     = 64;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_MULW   = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [2:0] op;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/ysyx_041461_mul_tagpipe.sv
// rtl/ysyx_041461_mul_tagpipe.sv - sideband {valid, op} shift register tracking ops through the tree
module ysyx_041461_mul_tagpipe
    import ysyx_041461_mul_pkg::*;
#(
    parameter int DEPTH = TREE_LAT
) (
    input  logic clk,
    input  logic clear,
    input  tag_t load_tag,
    output tag_t tail_tag,
    output logic any_valid
);

    tag_t stages [DEPTH];

    // The tree never stalls, so every stage advances unconditionally.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= load_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stages[i].valid;
        end
    end

    assign tail_tag = stages[DEPTH-1];

endmodule

// File: rtl/ysyx_041461_mul_final.sv
// rtl/ysyx_041461_mul_final.sv - carry-propagate add, RV64M result select and output handshake
module ysyx_041461_mul_final
    import ysyx_041461_mul_pkg::*;
#(
    parameter int TREE_LAT_P = TREE_LAT,
    parameter int COLS_P     = COLS,
    parameter int XLEN_P     = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [2:0]        in_op,
    output logic              in_ready,
    input  logic              in_flush,
    input  logic [COLS_P-1:0] tree_c,
    input  logic [COLS_P-1:0] tree_s,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN_P-1:0] out_result,
    output logic              busy
);

    localparam int PW = 2 * XLEN_P;

    logic            accepted;
    tag_t            load_tag;
    tag_t            tail_tag;
    logic            tags_busy;
    logic [PW-1:0]   sum;
    logic [XLEN_P-1:0] result;

    // Top columns and the last carry fall outside the 128-bit product.
    logic unused_cols;
    assign unused_cols = ^{tree_c[COLS_P-1:PW-1], tree_s[COLS_P-1:PW]};

    assign busy     = tags_busy | out_valid;
    assign in_ready = ~busy;
    assign accepted = in_valid & in_ready & ~in_flush;

    assign load_tag.valid = accepted;
    assign load_tag.op    = in_op;

    ysyx_041461_mul_tagpipe #(
        .DEPTH(TREE_LAT_P)
    ) u_tagpipe (
        .clk      (clk),
        .clear    (rst | in_flush),
        .load_tag (load_tag),
        .tail_tag (tail_tag),
        .any_valid(tags_busy)
    );

    assign sum = tree_s[PW-1:0] + {tree_c[PW-2:0], 1'b0};

    always_comb begin
        result = '0;
        case (tail_tag.op)
            OP_MUL:                      result = sum[XLEN_P-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: result = sum[PW-1:XLEN_P];
            OP_MULW:                     result = {{(XLEN_P/2){sum[XLEN_P/2-1]}}, sum[XLEN_P/2-1:0]};
            default:                     result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
        end else if (in_flush) begin
            out_valid <= 1'b0;
        end else if (tail_tag.valid) begin
            out_valid  <= 1'b1;
            out_result <= result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    // Issue gating guarantees a result never lands on an unconsumed one.
    assert property (@(posedge clk) disable iff (rst) !(tail_tag.valid && out_valid));
`endif

endmodule

// File: tb/tb_ysyx_041461_mul_final.sv
// tb/tb_ysyx_041461_mul_final.sv - directed self-checking bench for the multiplier final stage
module tb_ysyx_041461_mul_final;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [2:0]   in_op;
    logic         in_ready;
    logic         in_flush;
    logic [131:0] tree_c;
    logic [131:0] tree_s;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_result;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    localparam logic [131:0] JUNK_S = {33{4'hA}};
    localparam logic [131:0] JUNK_C = {33{4'h5}};

    ysyx_041461_mul_final dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_ready  (in_ready),
        .in_flush  (in_flush),
        .tree_c    (tree_c),
        .tree_s    (tree_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; tree outputs are presented only in cycle t+3 so a wrong latency shows up.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [131:0] s,
                          input logic [131:0] c, input logic [63:0] exp);
        check({tag, "_ready_pre"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        tick();
        in_valid = 1'b0;
        in_op    = 3'd7;
        check({tag, "_ready_t1"}, 64'(in_ready), 64'd0);
        tick();
        check({tag, "_ready_t2"}, 64'(in_ready), 64'd0);
        tick();
        tree_s = s;
        tree_c = c;
        check({tag, "_valid_t3"}, 64'(out_valid), 64'd0);
        tick();
        tree_s = JUNK_S;
        tree_c = JUNK_C;
        check({tag, "_valid_t4"}, 64'(out_valid), 64'd1);
        check({tag, "_result"}, out_result, exp);
        check({tag, "_ready_t4"}, 64'(in_ready), 64'd0);
        tick();
        check({tag, "_valid_t5"}, 64'(out_valid), 64'd0);
        check({tag, "_ready_t5"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_flush  = 1'b0;
        out_ready = 1'b1;
        tree_s    = JUNK_S;
        tree_c    = JUNK_C;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_result", out_result, 64'd0);
        tick();

        run_op("mul_basic", 3'd0, 132'd15, 132'd0, 64'd15);
        run_op("mul_carry", 3'd0, 132'h0_FFFF_FFFF_FFFF_FFFF, 132'd1, 64'd1);
        run_op("mulhu_carry", 3'd3, 132'h0_FFFF_FFFF_FFFF_FFFF, 132'd1, 64'd1);
        run_op("mulw_sext", 3'd4, 132'h8000_0000, 132'd0, 64'hFFFF_FFFF_8000_0000);
        run_op("mulh_ones", 3'd1, {132{1'b1}}, 132'd1 << 127, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulhsu_hi", 3'd2, {4'h0, 64'h0123_4567_89AB_CDEF, 64'h0}, 132'd0,
               64'h0123_4567_89AB_CDEF);
        run_op("reserved", 3'd5, 132'd15, 132'd0, 64'd0);

        // Backpressure with a dropped issue attempt.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op    = 3'd0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tree_s = 132'd7;
        tree_c = 132'd0;
        tick();
        tree_s = JUNK_S;
        tree_c = JUNK_C;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_result", out_result, 64'd7);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = (i == 2);
            tick();
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            check("bp_no_second", 64'(out_valid), 64'd0);
            tick();
        end

        // Flush two cycles after issue.
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("flush_no_valid", 64'(out_valid), 64'd0);
            tick();
        end

        // Flush coinciding with issue.
        in_valid = 1'b1;
        in_flush = 1'b1;
        tick();
        in_valid = 1'b0;
        in_flush = 1'b0;
        check("flush_issue_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 5; i++) begin
            check("flush_issue_no_valid", 64'(out_valid), 64'd0);
            tick();
        end

        // Flush while a result is held keeps the stale value.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op    = 3'd0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tree_s = 132'd42;
        tree_c = 132'd0;
        tick();
        tree_s = JUNK_S;
        tree_c = JUNK_C;
        check("hold_valid", 64'(out_valid), 64'd1);
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        out_ready = 1'b1;
        check("flush_hold_valid", 64'(out_valid), 64'd0);
        check("flush_hold_stale", out_result, 64'd42);
        check("flush_hold_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of an op.
        in_valid = 1'b1;
        in_op    = 3'd0;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        check("rstmid_valid_t1", 64'(out_valid), 64'd0);
        tick();
        check("rstmid_valid_t2", 64'(out_valid), 64'd0);
        tick();
        rst = 1'b0;
        check("rstmid_in_ready", 64'(in_ready), 64'd1);
        check("rstmid_result", out_result, 64'd0);
        for (int i = 0; i < 4; i++) begin
            check("rstmid_no_valid", 64'(out_valid), 64'd0);
            tick();
        end
        run_op("after_rst", 3'd0, 132'd100, 132'd3, 64'd106);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
